hog_gradient: RTL
=================

# hog_gradient

Computes per-pixel gradient magnitude and unsigned orientation bin for one pyramid level's pixel stream. It is the first HOG stage downstream of the Gaussian pyramid, and one instance is used per level. Input is a raster-order valid/ready pixel stream. Output is a valid/ready stream of (magnitude, bin) pairs for the interior pixels only, so an image of W×H produces (W−2)×(H−2) results per frame.

## Interface
- DATA_WIDTH, 8, pixel width (unsigned)
- IMAGE_WIDTH, 640, pixels per input line (W, ≥ 3)
- IMAGE_HEIGHT, 480, lines per input frame (H, ≥ 3)
- MAG_WIDTH, DATA_WIDTH+1, magnitude width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present
- in_ready  out  1  block accepts pixel this cycle
- pixel  in  DATA_WIDTH  input pixel, raster order
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- magnitude  out  MAG_WIDTH  |Gx|+|Gy|
- bin  out  4  orientation bin, 0–8

## Operation
- **Input accept:** an input pixel is accepted when in_valid && in_ready.
- **Counters:** col counts 0..W−1 and row counts 0..H−1. They advance only on accept. col wraps to 0 at W−1, which increments row. row wraps to 0 at H−1, which marks the frame end. There is no frame marker port.
- **Line buffers:** two line buffers of depth W hold rows y−1 and y−2. Column-delay registers supply the cross window around the centre (c−1, r−1), where (c, r) is the accepted pixel's position:
  - T = P(c−1, r−2)
  - B = P(c−1, r)
  - L = P(c−2, r−1)
  - R = P(c, r−1)
- **Output gating:** a window is emitted only if r ≥ 2 and c ≥ 2. Stale line-buffer data from a previous frame is never emitted, because the row gate covers it.
- **Gradients:** Gx = R − L and Gy = B − T, both signed DATA_WIDTH+1 bits. magnitude = |Gx| + |Gy|, which cannot overflow MAG_WIDTH (max 2·(2^DATA_WIDTH−1)).
- **Bin:** 9 bins of 20° covering 0–180° (unsigned orientation).
  - Fold: if Gy < 0, negate both Gx and Gy.
  - Let ax = |Gx| and gy = the folded Gy.
  - k = count of thresholds t in {93, 215, 443, 1452} (tan 20/40/60/80° × 256) satisfying gy·256 ≥ t·ax. Products are unsigned, DATA_WIDTH+12 bits.
  - If Gy = 0: bin = 0 (this covers Gx = Gy = 0).
  - Else if Gx ≥ 0: bin = k.
  - Else: bin = 8 − k.
- **Pipeline:** two register stages.
  - S1 registers T/B/L/R plus a valid bit.
  - S2 registers magnitude, bin and out_valid.
  - Global advance condition: adv = out_ready || !out_valid.
  - in_ready = adv, a combinational path from out_ready.
  - When adv = 0, all stages and counters hold and the outputs stay stable.
- **Reset (asynchronous):** col, row, S1 valid, out_valid, magnitude and bin all go to 0. in_ready is therefore 1 after reset. Line-buffer contents are don't-care.

## Timing
- **Latency:** the result for centre (c−1, r−1) appears on out_valid 2 cycles after pixel (c, r) is accepted, with no stalls.
- **Throughput:** 1 result per cycle when in_valid and out_ready are held high.
- Results leave in raster order of their centres, with none dropped or duplicated.
- **Frame wrap:** pixel (0, 0) of the next frame may be accepted the cycle after (W−1, H−1). The output count per frame is exactly (W−2)(H−2).
- **Reset mid-frame:** outputs go to 0 immediately (asynchronous). The next accepted pixel is treated as (0, 0) and no partial-frame results are produced.
- out_valid deasserts only after a handshake or on reset. magnitude and bin are stable while out_valid && !out_ready.

## Test plan
All scenarios use W = 8, H = 6 and in_valid, out_ready = 1 unless stated.
- **Constant frame:** pixel = 100 everywhere → 24 outputs, all magnitude = 0, bin = 0.
- **Horizontal ramp:** pixel = 4·col → 24 outputs, magnitude = 8, bin = 0.
- **Vertical ramp:** pixel = 10·row → magnitude = 20, bin = 4.
- **Diagonals:**
  - pixel = 5·col + 5·row → magnitude = 20, bin = 2.
  - pixel = 100 − 5·col + 5·row → magnitude = 20, bin = 6.
  - pixel = 100 − 5·col − 5·row → bin = 2 (fold check).
- **Backpressure and random valid:** out_ready random ~50%, in_valid random → the exact 24-result sequence matches the reference model, out_valid/magnitude/bin stay stable while stalled, and in_ready == (out_ready || !out_valid) every cycle. Two back-to-back frames → 48 results, the second frame unaffected by the first.
- **Reset mid-frame:** assert rst after 20 pixels → out_valid = 0 immediately. A full frame then yields exactly 24 correct results.

Source files
------------

// File: rtl/hog_gradient.sv
// HOG front end: per-pixel |Gx|+|Gy| magnitude and 9-bin unsigned orientation
// over a raster pixel stream, emitting interior pixels only.
module hog_gradient #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int MAG_WIDTH    = DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAG_WIDTH-1:0]  magnitude,
  output logic [3:0]            bin
);

  localparam int DW     = DATA_WIDTH;
  localparam int CW     = $clog2(IMAGE_WIDTH);
  localparam int RW     = $clog2(IMAGE_HEIGHT);
  localparam int PW     = DATA_WIDTH + 12;
  localparam int STAGES = 2;
  // tan(20/40/60/80 deg) * 256
  localparam logic [3:0][10:0] THR = {11'd1452, 11'd443, 11'd215, 11'd93};

  typedef struct packed {
    logic [DW-1:0] t;
    logic [DW-1:0] b;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } win_t;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              adv, acc, gate;
  logic [STAGES:1]   vld_pipe;
  logic [DW-1:0]     lb1 [IMAGE_WIDTH];
  logic [DW-1:0]     lb2 [IMAGE_WIDTH];
  logic [DW-1:0]     mid_d1, mid_d2, top_d1, bot_d1;
  win_t              win, s1_win;

  logic signed [DW:0] gx, gy;
  logic [DW:0]        ax, ay;
  logic [PW-1:0]      gy_sh;
  logic               fgx_neg;
  logic [2:0]         k;
  logic [3:0]         bin_c;
  logic [MAG_WIDTH-1:0] mag_c;

  // One global stall: every stage and the counters freeze together.
  assign adv       = out_ready || !vld_pipe[STAGES];
  assign in_ready  = adv;
  assign acc       = in_valid && adv;
  assign out_valid = vld_pipe[STAGES];
  assign gate      = (col >= CW'(2)) && (row >= RW'(2));

  // Cross window centred one row up and one column left of the incoming pixel.
  always_comb begin
    win   = '0;
    win.t = top_d1;
    win.b = bot_d1;
    win.l = mid_d2;
    win.r = lb1[col];
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[col] <= pixel;
      lb2[col] <= lb1[col];
      mid_d1   <= lb1[col];
      mid_d2   <= mid_d1;
      top_d1   <= lb2[col];
      bot_d1   <= pixel;
    end
    if (adv) s1_win <= win;
  end

  always_comb begin
    gx    = $signed({1'b0, s1_win.r}) - $signed({1'b0, s1_win.l});
    gy    = $signed({1'b0, s1_win.b}) - $signed({1'b0, s1_win.t});
    ax    = gx[DW] ? $unsigned(-gx) : $unsigned(gx);
    ay    = gy[DW] ? $unsigned(-gy) : $unsigned(gy);
    mag_c = MAG_WIDTH'(ax) + MAG_WIDTH'(ay);
    // Folding negates Gx when Gy < 0, so the folded sign flips.
    fgx_neg = gy[DW] ? (!gx[DW] && (gx != '0)) : gx[DW];
    gy_sh = PW'(ay) << 8;
    k     = '0;
    for (int i = 0; i < 4; i++)
      if (gy_sh >= PW'(ax) * PW'(THR[i])) k = k + 3'd1;
    if (ay == '0)    bin_c = 4'd0;
    else if (!fgx_neg) bin_c = {1'b0, k};
    else             bin_c = 4'd8 - {1'b0, k};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      vld_pipe  <= '0;
      magnitude <= '0;
      bin       <= '0;
    end else begin
      if (acc) begin
        if (col == CW'(IMAGE_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(IMAGE_HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (adv) begin
        vld_pipe[1] <= acc && gate;
        vld_pipe[2] <= vld_pipe[1];
        magnitude   <= mag_c;
        bin         <= bin_c;
      end
    end
  end

endmodule
